// File: rtl/serial_queue_ctrl.sv
// -----------------------------------------------------------------------------
// serial_queue_ctrl
//
// Bit-serial byte queue controller. Serial bits are collected into a WIDTH-bit
// word, pushed into a DEPTH-entry circular queue on enqueue, and popped and
// shifted out MSB first on dequeue. Single clock domain (clock_1MHz).
//
// Ports:
//   clock_1MHz      sole clock, rising edge
//   rst             asynchronous active-high reset
//   data_in         serial input bit
//   write_in        shift data_in into the collector
//   enqueue_in      push the collected word into the queue
//   dequeue_in      pop head word and start serial output
//   status_out      collector can accept bits (fewer than WIDTH collected)
//   data_out        serial output bit, MSB first
//   data_valid_out  data_out carries a transmitted bit
//   full_out        queue holds DEPTH words
//   empty_out       queue holds 0 words
//   drop_out        one-cycle pulse after a refused enqueue/dequeue
//   level_out       registered occupancy (only with SERIAL_QUEUE_LEVEL_EN)
//
// Configuration macro: SERIAL_QUEUE_LEVEL_EN adds the level_out port.
// -----------------------------------------------------------------------------
module serial_queue_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic clock_1MHz,
  input  logic rst,
  input  logic data_in,
  input  logic write_in,
  input  logic enqueue_in,
  input  logic dequeue_in,
  output logic status_out,
  output logic data_out,
  output logic data_valid_out,
  output logic full_out,
  output logic empty_out,
  output logic drop_out
`ifdef SERIAL_QUEUE_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level_out
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int TW = $clog2(WIDTH);
  localparam logic [CW-1:0] COLL_FULL = CW'(WIDTH);
  localparam logic [TW-1:0] TX_LAST   = TW'(WIDTH - 1);
  localparam logic [AW:0]   OCC_FULL  = (AW + 1)'(DEPTH);

  typedef enum logic {IDLE, SHIFT} tx_state_e;

  tx_state_e         state_q, state_d;
  logic [WIDTH-1:0]  coll_shreg_q, coll_shreg_d;
  logic [CW-1:0]     coll_cnt_q, coll_cnt_d;
  logic [WIDTH-1:0]  tx_shreg_q, tx_shreg_d;
  logic [TW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [AW:0]       occ_q, occ_d;
  logic              drop_q, drop_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic coll_full, tx_ready;
  logic enq_acc, enq_ref, deq_acc, deq_ref;

  assign coll_full = (coll_cnt_q == COLL_FULL);
  // The last SHIFT cycle can already accept the next pop, so back-to-back
  // words stream with no idle gap.
  assign tx_ready  = (state_q == IDLE) || (tx_cnt_q == '0);

  assign deq_acc = dequeue_in && tx_ready && !empty_out;
  assign deq_ref = dequeue_in && tx_ready && empty_out;
  // A full queue still takes a word when the head leaves on the same edge.
  assign enq_acc = enqueue_in && coll_full && (!full_out || deq_acc);
  assign enq_ref = enqueue_in && coll_full && full_out && !deq_acc;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch); combinational logic uses blocking '='.
    state_d      = state_q;
    coll_shreg_d = coll_shreg_q;
    coll_cnt_d   = coll_cnt_q;
    tx_shreg_d   = tx_shreg_q;
    tx_cnt_d     = tx_cnt_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    occ_d        = occ_q;
    drop_d       = enq_ref || deq_ref;

    // Collector
    if (enq_acc) begin
      coll_cnt_d = '0;
      wptr_d     = wptr_q + AW'(1);
    end else if (write_in && !coll_full) begin
      coll_shreg_d = {coll_shreg_q[WIDTH-2:0], data_in};
      coll_cnt_d   = coll_cnt_q + CW'(1);
    end

    if (deq_acc) rptr_d = rptr_q + AW'(1);

    case ({enq_acc, deq_acc})
      2'b10:   occ_d = occ_q + (AW + 1)'(1);
      2'b01:   occ_d = occ_q - (AW + 1)'(1);
      default: occ_d = occ_q;
    endcase

    // Transmitter
    case (state_q)
      IDLE: begin
        if (deq_acc) begin
          tx_shreg_d = mem_q[rptr_q];
          tx_cnt_d   = TX_LAST;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        tx_shreg_d = {tx_shreg_q[WIDTH-2:0], 1'b0};
        tx_cnt_d   = tx_cnt_q - TW'(1);
        if (tx_cnt_q == '0) begin
          if (deq_acc) begin
            tx_shreg_d = mem_q[rptr_q];
            tx_cnt_d   = TX_LAST;
          end else begin
            tx_cnt_d = '0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_1MHz or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      coll_shreg_q <= '0;
      coll_cnt_q   <= '0;
      tx_shreg_q   <= '0;
      tx_cnt_q     <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      occ_q        <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      coll_shreg_q <= coll_shreg_d;
      coll_cnt_q   <= coll_cnt_d;
      tx_shreg_q   <= tx_shreg_d;
      tx_cnt_q     <= tx_cnt_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      occ_q        <= occ_d;
      drop_q       <= drop_d;
    end
  end

  // NOTE: the storage array has no reset; clearing the pointers and occupancy
  // already discards its contents, and stale entries are never read.
  always_ff @(posedge clock_1MHz) begin
    if (enq_acc) mem_q[wptr_q] <= coll_shreg_q;
  end

  assign status_out     = !coll_full;
  assign data_valid_out = (state_q == SHIFT);
  assign data_out       = (state_q == SHIFT) && tx_shreg_q[WIDTH-1];
  assign full_out       = (occ_q == OCC_FULL);
  assign empty_out      = (occ_q == '0);
  assign drop_out       = drop_q;

`ifdef SERIAL_QUEUE_LEVEL_EN
  assign level_out = occ_q;
`endif

endmodule
